// File: rtl/sys_reset_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_reset_ctrl: system reset request from two-step software reset or WDT.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sys_reset_ctrl #(
  parameter int unsigned WDT_WIDTH          = 32,
  parameter int unsigned ARM_WINDOW         = 255,
  parameter int unsigned RESET_PULSE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_reset_arm,
  input  logic                 sw_reset_confirm,
  input  logic                 wdt_start,
  input  logic                 wdt_stop,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_timeout,
  output logic                 sys_reset,
  output logic [1:0]           sys_reset_cause,
  output logic                 wdt_running,
  output logic                 sw_reset_armed
);

  localparam int unsigned      WIN_W        = $clog2(ARM_WINDOW + 1);
  localparam logic [WIN_W-1:0] C_ARM_WIN    = WIN_W'(ARM_WINDOW);
  localparam logic [7:0]       C_PULSE_LAST = 8'(RESET_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  logic [WDT_WIDTH-1:0] wdt_ctr_q, wdt_ctr_d;
  logic                 wdt_run_q, wdt_run_d;
  logic                 wdt_trig;

  // Expiry is decided from registered state, so a kick arriving with ctr==0 is too late.
  assign wdt_trig = wdt_run_q && (wdt_ctr_q == '0);

  always_comb begin
    wdt_ctr_d = wdt_ctr_q;
    wdt_run_d = wdt_run_q;
    if (wdt_stop) begin
      wdt_run_d = 1'b0;
    end else if (wdt_trig) begin
      wdt_run_d = 1'b0;
    end else if (wdt_start || (wdt_kick && wdt_run_q)) begin
      wdt_ctr_d = wdt_timeout;
      wdt_run_d = 1'b1;
    end else if (wdt_run_q) begin
      wdt_ctr_d = wdt_ctr_q - WDT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_ctr_q <= '0;
      wdt_run_q <= 1'b0;
    end else begin
      wdt_ctr_q <= wdt_ctr_d;
      wdt_run_q <= wdt_run_d;
    end
  end

  state_e           state_q;
  logic [WIN_W-1:0] win_q;
  logic [7:0]       pcnt_q;
  logic             sys_reset_q;
  logic [1:0]       cause_q;
  logic             armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      pcnt_q      <= '0;
      sys_reset_q <= 1'b0;
      cause_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wdt_trig) begin
            state_q     <= ST_PULSE;
            pcnt_q      <= C_PULSE_LAST;
            sys_reset_q <= 1'b1;
            cause_q     <= 2'b10;
          end else if (sw_reset_arm) begin
            state_q <= ST_ARMED;
            win_q   <= C_ARM_WIN;
            armed_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (sw_reset_confirm || wdt_trig) begin
            state_q     <= ST_PULSE;
            pcnt_q      <= C_PULSE_LAST;
            sys_reset_q <= 1'b1;
            cause_q     <= {wdt_trig, sw_reset_confirm};
            armed_q     <= 1'b0;
            win_q       <= '0;
          end else if (sw_reset_arm) begin
            win_q <= C_ARM_WIN;
          end else if (win_q <= WIN_W'(1)) begin
            // Last window cycle: the decrement lands on 0, so leave now.
            state_q <= ST_IDLE;
            win_q   <= '0;
            armed_q <= 1'b0;
          end else begin
            win_q <= win_q - WIN_W'(1);
          end
        end
        ST_PULSE: begin
          if (pcnt_q == 8'd0) begin
            state_q     <= ST_LOCK;
            sys_reset_q <= 1'b0;
            cause_q     <= 2'b00;
          end else begin
            pcnt_q <= pcnt_q - 8'd1;
          end
        end
        ST_LOCK: begin
          state_q <= ST_LOCK;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sys_reset       = sys_reset_q;
  assign sys_reset_cause = cause_q;
  assign wdt_running     = wdt_run_q;
  assign sw_reset_armed  = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_reset_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sys_reset_ctrl: directed self-checking bench for sys_reset_ctrl.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sys_reset_ctrl;

  logic        clk;
  logic        rst;
  logic        sw_reset_arm;
  logic        sw_reset_confirm;
  logic        wdt_start;
  logic        wdt_stop;
  logic        wdt_kick;
  logic [31:0] wdt_timeout;
  logic        sys_reset;
  logic [1:0]  sys_reset_cause;
  logic        wdt_running;
  logic        sw_reset_armed;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic seen;

  sys_reset_ctrl #(
    .WDT_WIDTH(32),
    .ARM_WINDOW(255),
    .RESET_PULSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_reset_arm(sw_reset_arm),
    .sw_reset_confirm(sw_reset_confirm),
    .wdt_start(wdt_start),
    .wdt_stop(wdt_stop),
    .wdt_kick(wdt_kick),
    .wdt_timeout(wdt_timeout),
    .sys_reset(sys_reset),
    .sys_reset_cause(sys_reset_cause),
    .wdt_running(wdt_running),
    .sw_reset_armed(sw_reset_armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  // One clock: inputs set now are sampled at the next edge; outputs read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst = 1'b1;
    sw_reset_arm = 1'b0;
    sw_reset_confirm = 1'b0;
    wdt_start = 1'b0;
    wdt_stop = 1'b0;
    wdt_kick = 1'b0;
    wdt_timeout = 32'd0;

    // Reset state
    step();
    step();
    check("rst_sys_reset", 32'(sys_reset), 32'd0);
    check("rst_cause", 32'(sys_reset_cause), 32'd0);
    check("rst_running", 32'(wdt_running), 32'd0);
    check("rst_armed", 32'(sw_reset_armed), 32'd0);

    // 1: arm@10, confirm@20 -> pulse 21..24, cause 01, LOCK ignores later events
    do_reset();
    goto(10); sw_reset_arm = 1'b1; step(); sw_reset_arm = 1'b0;
    check("t1_armed", 32'(sw_reset_armed), 32'd1);
    goto(20); sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    check("t1_rst_21", 32'(sys_reset), 32'd1);
    check("t1_cause_21", 32'(sys_reset_cause), 32'd1);
    check("t1_armed_21", 32'(sw_reset_armed), 32'd0);
    goto(24);
    check("t1_rst_24", 32'(sys_reset), 32'd1);
    check("t1_cause_24", 32'(sys_reset_cause), 32'd1);
    goto(25);
    check("t1_rst_25", 32'(sys_reset), 32'd0);
    check("t1_cause_25", 32'(sys_reset_cause), 32'd0);
    sw_reset_arm = 1'b1; step(); sw_reset_arm = 1'b0;
    sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    step();
    check("t1_lock_armed", 32'(sw_reset_armed), 32'd0);
    check("t1_lock_rst", 32'(sys_reset), 32'd0);

    // 2: window expiry; confirm@300 ignored
    do_reset();
    goto(10); sw_reset_arm = 1'b1; step(); sw_reset_arm = 1'b0;
    goto(265);
    check("t2_armed_265", 32'(sw_reset_armed), 32'd1);
    goto(266);
    check("t2_armed_266", 32'(sw_reset_armed), 32'd0);
    goto(300); sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    check("t2_rst_301", 32'(sys_reset), 32'd0);
    goto(305);
    check("t2_rst_305", 32'(sys_reset), 32'd0);

    // 3: start T=100 @0, kick @50 -> ctr 0 at 151, sys_reset at 152
    do_reset();
    wdt_timeout = 32'd100;
    wdt_start = 1'b1; step(); wdt_start = 1'b0;
    check("t3_running_1", 32'(wdt_running), 32'd1);
    goto(50); wdt_kick = 1'b1; step(); wdt_kick = 1'b0;
    goto(151);
    check("t3_rst_151", 32'(sys_reset), 32'd0);
    goto(152);
    check("t3_rst_152", 32'(sys_reset), 32'd1);
    check("t3_cause_152", 32'(sys_reset_cause), 32'd2);
    check("t3_running_152", 32'(wdt_running), 32'd0);

    // 4: start T=20 @0, stop @10 -> never fires
    do_reset();
    wdt_timeout = 32'd20;
    wdt_start = 1'b1; step(); wdt_start = 1'b0;
    goto(10);
    check("t4_running_10", 32'(wdt_running), 32'd1);
    wdt_stop = 1'b1; step(); wdt_stop = 1'b0;
    check("t4_running_11", 32'(wdt_running), 32'd0);
    seen = 1'b0;
    while (cyc < 1000) begin
      step();
      if (sys_reset) seen = 1'b1;
    end
    check("t4_no_reset", 32'(seen), 32'd0);

    // 4b: T=0 -> sys_reset two cycles after start
    do_reset();
    wdt_timeout = 32'd0;
    wdt_start = 1'b1; step(); wdt_start = 1'b0;
    check("t4b_rst_1", 32'(sys_reset), 32'd0);
    step();
    check("t4b_rst_2", 32'(sys_reset), 32'd1);
    check("t4b_cause_2", 32'(sys_reset_cause), 32'd2);

    // 4c: kick in the cycle ctr==0 is too late (T=5 @0 -> ctr 0 at 6)
    do_reset();
    wdt_timeout = 32'd5;
    wdt_start = 1'b1; step(); wdt_start = 1'b0;
    goto(6); wdt_kick = 1'b1; step(); wdt_kick = 1'b0;
    check("t4c_rst_7", 32'(sys_reset), 32'd1);

    // 5: armed, confirm when watchdog ctr==0 (T=20 @0 -> ctr 0 at 21)
    do_reset();
    wdt_timeout = 32'd20;
    wdt_start = 1'b1; step(); wdt_start = 1'b0;
    goto(5); sw_reset_arm = 1'b1; step(); sw_reset_arm = 1'b0;
    goto(21); sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    check("t5_rst_22", 32'(sys_reset), 32'd1);
    check("t5_cause_22", 32'(sys_reset_cause), 32'd3);
    goto(25);
    check("t5_rst_25", 32'(sys_reset), 32'd1);
    goto(26);
    check("t5_rst_26", 32'(sys_reset), 32'd0);

    // 6: rst mid-pulse, then arm+confirm together (arm only), confirm -> new pulse
    do_reset();
    goto(2); sw_reset_arm = 1'b1; step(); sw_reset_arm = 1'b0;
    sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    check("t6_rst_4", 32'(sys_reset), 32'd1);
    goto(5); rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_6", 32'(sys_reset), 32'd0);
    check("t6_cause_6", 32'(sys_reset_cause), 32'd0);
    goto(8);
    sw_reset_arm = 1'b1; sw_reset_confirm = 1'b1; step();
    sw_reset_arm = 1'b0; sw_reset_confirm = 1'b0;
    check("t6_armed_9", 32'(sw_reset_armed), 32'd1);
    check("t6_rst_9", 32'(sys_reset), 32'd0);
    sw_reset_confirm = 1'b1; step(); sw_reset_confirm = 1'b0;
    check("t6_rst_10", 32'(sys_reset), 32'd1);
    check("t6_cause_10", 32'(sys_reset_cause), 32'd1);
    goto(13);
    check("t6_rst_13", 32'(sys_reset), 32'd1);
    goto(14);
    check("t6_rst_14", 32'(sys_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
